// File: rtl/vec_seq_ctrl.sv
// vec_seq_ctrl: feeds operand bytes and single-cycle load/enable strobes to the 4-lane datapath.
// Latency: first strobe 1 cycle after command (MAC/FLUSH) or operand (LOAD) accept; done rides with the final strobe.
// Backpressure: waits with all strobes low while data_valid is low; VSEQ_TIMEOUT_EN aborts a wait after TIMEOUT cycles.
module vec_seq_ctrl #(
  parameter int DW      = 8,
  parameter int TIMEOUT = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cmd_valid,
  input  logic [1:0]    cmd_op,
  output logic          cmd_ready,
  input  logic [DW-1:0] data_in,
  input  logic          data_valid,
  output logic          data_ready,
  output logic [DW-1:0] din,
  output logic          en_a1, en_a2, en_a3, en_a4,
  output logic          en_b1, en_b2, en_b3, en_b4,
  output logic          save_c,
  output logic          en_add1_1, en_add1_2, en_add1_3, en_add1_4,
  output logic          en_add2_1, en_add2_2, en_add2_3, en_add2_4,
  output logic          en_f1, en_f2, en_f3, en_f4,
  output logic          busy,
  output logic          done,
  output logic          err
);

  localparam logic [2:0] S_IDLE = 3'd0, S_LOAD = 3'd1, S_MUL = 3'd2, S_ADD1 = 3'd3,
                         S_ADD2 = 3'd4, S_OUT = 3'd5, S_DONE = 3'd6;
  localparam logic [1:0] OP_MAC = 2'b10, OP_FLUSH = 2'b11;

  logic [2:0]    r_state, w_state_nxt;
  logic [1:0]    r_ln, w_ln_nxt, w_ln_inc;
  logic [1:0]    r_op;
  logic          w_cmd_acc, w_dat_acc, w_tmo;
  logic [DW-1:0] r_din, w_din;
  logic [3:0]    r_en_a, r_en_b, r_add1, r_add2, r_f;
  logic [3:0]    w_en_a, w_en_b, w_add1, w_add2, w_f;
  logic          r_save_c, r_done, w_save_c, w_done;

  assign cmd_ready  = (r_state == S_IDLE);
  assign busy       = (r_state != S_IDLE);
  assign data_ready = (r_state == S_LOAD) || (r_state == S_MUL);
  assign w_cmd_acc  = cmd_valid && cmd_ready;
  assign w_dat_acc  = data_valid && data_ready;
  assign w_ln_inc   = r_ln + 2'd1;

`ifdef VSEQ_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] r_tmo;
  logic          r_err;

  // The edge that would bring the stall count to TIMEOUT aborts the wait.
  assign w_tmo = data_ready && !data_valid && (r_tmo == CW'(TIMEOUT - 1));
  assign err   = r_err;

  // Stall counter: counts wait cycles without an accept, clears otherwise.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_tmo <= '0;
      r_err <= 1'b0;
    end else begin
      r_err <= w_tmo;
      if (data_ready && !data_valid && !w_tmo) r_tmo <= r_tmo + 1'b1;
      else                                     r_tmo <= '0;
    end
  end
`else
  // No stall limit in this build: waits are unbounded and err never fires.
  assign w_tmo = 1'b0;
  assign err   = (TIMEOUT < 0);
`endif

  // State register plus latched command opcode.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_ln    <= 2'd0;
      r_op    <= 2'b00;
    end else begin
      r_state <= w_state_nxt;
      r_ln    <= w_ln_nxt;
      if (w_cmd_acc) r_op <= cmd_op;
    end
  end

  // Next-state logic: walks lanes through each operation's fixed strobe order.
  always_comb begin
    w_state_nxt = r_state;
    w_ln_nxt    = r_ln;
    case (r_state)
      S_IDLE: if (w_cmd_acc) begin
        w_ln_nxt = 2'd0;
        case (cmd_op)
          OP_MAC:   w_state_nxt = S_MUL;
          OP_FLUSH: w_state_nxt = S_OUT;
          default:  w_state_nxt = S_LOAD;
        endcase
      end
      S_LOAD: begin
        if (w_tmo) w_state_nxt = S_IDLE;
        else if (w_dat_acc) begin
          if (r_ln == 2'd3) w_state_nxt = S_DONE;
          else              w_ln_nxt    = w_ln_inc;
        end
      end
      S_MUL: begin
        if (w_tmo)          w_state_nxt = S_IDLE;
        else if (w_dat_acc) w_state_nxt = S_ADD1;
      end
      S_ADD1: w_state_nxt = S_ADD2;
      S_ADD2: w_state_nxt = (r_ln == 2'd3) ? S_DONE : S_OUT;
      S_OUT: begin
        if (r_op == OP_FLUSH) begin
          if (r_ln == 2'd2) w_state_nxt = S_DONE;
          w_ln_nxt = w_ln_inc;
        end else begin
          w_state_nxt = S_MUL;
          w_ln_nxt    = w_ln_inc;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Output logic: next values of the registered strobes, din and done.
  always_comb begin
    w_din    = r_din;
    w_en_a   = 4'd0;
    w_en_b   = 4'd0;
    w_add1   = 4'd0;
    w_add2   = 4'd0;
    w_f      = 4'd0;
    w_save_c = 1'b0;
    w_done   = 1'b0;
    case (r_state)
      S_IDLE: if (w_cmd_acc) begin
        if (cmd_op == OP_MAC)   w_save_c = 1'b1;
        if (cmd_op == OP_FLUSH) w_f[0]   = 1'b1;
      end
      S_LOAD: if (w_dat_acc) begin
        w_din = data_in;
        if (r_op[0]) w_en_b[r_ln] = 1'b1;
        else         w_en_a[r_ln] = 1'b1;
        w_done = (r_ln == 2'd3);
      end
      S_MUL: if (w_dat_acc) begin
        w_din        = data_in;
        w_add1[r_ln] = 1'b1;
      end
      S_ADD1: w_add2[r_ln] = 1'b1;
      S_ADD2: begin
        w_f[r_ln] = 1'b1;
        w_done    = (r_ln == 2'd3);
      end
      S_OUT: begin
        if (r_op == OP_FLUSH) begin
          w_f[w_ln_inc] = 1'b1;
          w_done        = (r_ln == 2'd2);
        end else begin
          w_save_c = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Datapath-facing output registers; reset drops any strobe in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_din    <= '0;
      r_en_a   <= 4'd0;
      r_en_b   <= 4'd0;
      r_add1   <= 4'd0;
      r_add2   <= 4'd0;
      r_f      <= 4'd0;
      r_save_c <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_din    <= w_din;
      r_en_a   <= w_en_a;
      r_en_b   <= w_en_b;
      r_add1   <= w_add1;
      r_add2   <= w_add2;
      r_f      <= w_f;
      r_save_c <= w_save_c;
      r_done   <= w_done;
    end
  end

  assign din    = r_din;
  assign save_c = r_save_c;
  assign done   = r_done;
  assign {en_a4, en_a3, en_a2, en_a1}                 = r_en_a;
  assign {en_b4, en_b3, en_b2, en_b1}                 = r_en_b;
  assign {en_add1_4, en_add1_3, en_add1_2, en_add1_1} = r_add1;
  assign {en_add2_4, en_add2_3, en_add2_2, en_add2_1} = r_add2;
  assign {en_f4, en_f3, en_f2, en_f1}                 = r_f;

endmodule

// File: tb/tb_vec_seq_ctrl.sv
// tb_vec_seq_ctrl: directed command sequences against hand-computed strobe timelines.
// Latency: each command is observed cycle by cycle from W(0) onward.
// Backpressure: operand stalls and command re-assertion are driven explicitly.
module tb_vec_seq_ctrl;
  logic       clk = 1'b0;
  logic       rst;
  logic       cmd_valid, cmd_ready, data_valid, data_ready;
  logic [1:0] cmd_op;
  logic [7:0] data_in, din;
  logic       en_a1, en_a2, en_a3, en_a4, en_b1, en_b2, en_b3, en_b4, save_c;
  logic       en_add1_1, en_add1_2, en_add1_3, en_add1_4;
  logic       en_add2_1, en_add2_2, en_add2_3, en_add2_4;
  logic       en_f1, en_f2, en_f3, en_f4, busy, done, err;

  vec_seq_ctrl #(.DW(8), .TIMEOUT(16)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_op(cmd_op), .cmd_ready(cmd_ready),
    .data_in(data_in), .data_valid(data_valid), .data_ready(data_ready), .din(din),
    .en_a1(en_a1), .en_a2(en_a2), .en_a3(en_a3), .en_a4(en_a4),
    .en_b1(en_b1), .en_b2(en_b2), .en_b3(en_b3), .en_b4(en_b4), .save_c(save_c),
    .en_add1_1(en_add1_1), .en_add1_2(en_add1_2), .en_add1_3(en_add1_3), .en_add1_4(en_add1_4),
    .en_add2_1(en_add2_1), .en_add2_2(en_add2_2), .en_add2_3(en_add2_3), .en_add2_4(en_add2_4),
    .en_f1(en_f1), .en_f2(en_f2), .en_f3(en_f3), .en_f4(en_f4),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  logic [21:0] o_stb[32];
  logic [7:0]  o_din[32];
  logic        o_rdy[32];
  logic        o_busy[32];
  logic        o_err[32];
  logic [7:0]  bytes[4];
  logic [21:0] e_stb[32];

  localparam logic [21:0] SC = 22'h1 << 20;
  localparam logic [21:0] DN = 22'h1 << 21;

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // base: 0 en_a, 4 en_b, 8 en_add1, 12 en_add2, 16 en_f; k = lane 1..4
  function automatic logic [21:0] mk(input int base, input int k);
    return 22'h1 << (base + k - 1);
  endfunction

  function automatic logic [21:0] strobes();
    return {done, save_c, en_f4, en_f3, en_f2, en_f1,
            en_add2_4, en_add2_3, en_add2_2, en_add2_1,
            en_add1_4, en_add1_3, en_add1_2, en_add1_1,
            en_b4, en_b3, en_b2, en_b1, en_a4, en_a3, en_a2, en_a1};
  endfunction

  // Issues a command at edge 0, then records W(0)..W(ncyc-1).
  task automatic run_cmd(input logic [1:0] op, input int nbytes, input int stall_idx,
                         input int stall_len, input int ncyc, input int reassert_w, input int rst_w);
    int bi, sc;
    logic dv, acc_d, acc_c;
    bi = 0;
    sc = 0;
    chk_eq("cmd_ready_before_issue", cmd_ready, 1);
    cmd_op = op;
    cmd_valid = 1'b1;
    data_valid = 1'b0;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    for (int w = 0; w < ncyc; w++) begin
      o_stb[w] = strobes(); o_din[w] = din; o_rdy[w] = cmd_ready;
      o_busy[w] = busy; o_err[w] = err;
      if (w == reassert_w) begin cmd_valid = 1'b1; cmd_op = 2'b00; end
      if (w == rst_w) rst = 1'b1;
      dv = (bi < nbytes) && !(bi == stall_idx && sc < stall_len);
      if (data_ready && !dv && bi == stall_idx) sc++;
      data_valid = dv;
      data_in = (bi < 4) ? bytes[bi] : 8'h00;
      acc_d = data_ready && dv;
      acc_c = cmd_valid && cmd_ready;
      @(posedge clk); #1;
      rst = 1'b0;
      if (acc_d) bi++;
      if (acc_c) cmd_valid = 1'b0;
    end
    data_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required finish before 200000");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; cmd_valid = 1'b0; cmd_op = 2'b00; data_valid = 1'b0; data_in = 8'h00;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // reset state
    chk_eq("rst_strobes", strobes(), 0);
    chk_eq("rst_din", din, 0);
    chk_eq("rst_cmd_ready", cmd_ready, 1);
    chk_eq("rst_busy", busy, 0);
    chk_eq("rst_data_ready", data_ready, 0);
    chk_eq("rst_err", err, 0);

    // LOAD_A, no stalls
    bytes[0] = 8'd10; bytes[1] = 8'd20; bytes[2] = 8'd30; bytes[3] = 8'd40;
    run_cmd(2'b00, 4, -1, 0, 6, -1, -1);
    e_stb[0] = 0; e_stb[1] = mk(0,1); e_stb[2] = mk(0,2); e_stb[3] = mk(0,3);
    e_stb[4] = mk(0,4) | DN; e_stb[5] = 0;
    for (int w = 0; w < 6; w++) begin
      chk_eq($sformatf("loada_stb_w%0d", w), o_stb[w], e_stb[w]);
      chk_eq($sformatf("loada_err_w%0d", w), o_err[w], 0);
    end
    for (int w = 1; w < 5; w++) chk_eq($sformatf("loada_din_w%0d", w), o_din[w], bytes[w-1]);
    chk_eq("loada_rdy_w4", o_rdy[4], 0);
    chk_eq("loada_rdy_w5", o_rdy[5], 1);
    chk_eq("loada_busy_w0", o_busy[0], 1);
    chk_eq("loada_busy_w4", o_busy[4], 1);
    chk_eq("loada_busy_w5", o_busy[5], 0);

    // LOAD_B, 3-cycle stall before the third byte
    bytes[0] = 8'hFB; bytes[1] = 8'hF1; bytes[2] = 8'hE7; bytes[3] = 8'hDD;
    run_cmd(2'b01, 4, 2, 3, 9, -1, -1);
    e_stb[0] = 0; e_stb[1] = mk(4,1); e_stb[2] = mk(4,2); e_stb[3] = 0; e_stb[4] = 0;
    e_stb[5] = 0; e_stb[6] = mk(4,3); e_stb[7] = mk(4,4) | DN; e_stb[8] = 0;
    for (int w = 0; w < 9; w++) chk_eq($sformatf("loadb_stb_w%0d", w), o_stb[w], e_stb[w]);
    chk_eq("loadb_din_hold_w4", o_din[4], 8'hF1);
    chk_eq("loadb_din_w6", o_din[6], 8'hE7);
    chk_eq("loadb_din_w7", o_din[7], 8'hDD);
    chk_eq("loadb_rdy_w8", o_rdy[8], 1);

    // MAC over four lanes
    bytes[0] = 8'd7; bytes[1] = 8'd8; bytes[2] = 8'd9; bytes[3] = 8'd10;
    run_cmd(2'b10, 4, -1, 0, 17, -1, -1);
    for (int i = 0; i < 4; i++) begin
      e_stb[4*i]   = SC;
      e_stb[4*i+1] = mk(8, i+1);
      e_stb[4*i+2] = mk(12, i+1);
      e_stb[4*i+3] = mk(16, i+1) | ((i == 3) ? DN : 22'h0);
    end
    e_stb[16] = 0;
    for (int w = 0; w < 17; w++) chk_eq($sformatf("mac_stb_w%0d", w), o_stb[w], e_stb[w]);
    for (int i = 0; i < 4; i++) chk_eq($sformatf("mac_din_lane%0d", i+1), o_din[4*i+1], bytes[i]);
    chk_eq("mac_rdy_w15", o_rdy[15], 0);
    chk_eq("mac_busy_w15", o_busy[15], 1);
    chk_eq("mac_rdy_w16", o_rdy[16], 1);

    // FLUSH with a LOAD_A command held from W(1)
    run_cmd(2'b11, 0, -1, 0, 6, 1, -1);
    e_stb[0] = mk(16,1); e_stb[1] = mk(16,2); e_stb[2] = mk(16,3);
    e_stb[3] = mk(16,4) | DN; e_stb[4] = 0; e_stb[5] = 0;
    for (int w = 0; w < 6; w++) chk_eq($sformatf("flush_stb_w%0d", w), o_stb[w], e_stb[w]);
    for (int w = 1; w < 4; w++) chk_eq($sformatf("flush_rdy_w%0d", w), o_rdy[w], 0);
    chk_eq("flush_rdy_w4", o_rdy[4], 1);
    chk_eq("flush_second_cmd_rdy_w5", o_rdy[5], 0);
    chk_eq("flush_second_cmd_busy_w5", o_busy[5], 1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk_eq("rst_mid_load_rdy", cmd_ready, 1);
    chk_eq("rst_mid_load_busy", busy, 0);

    // MAC aborted by reset during W(6)
    bytes[0] = 8'd7; bytes[1] = 8'd8; bytes[2] = 8'd9; bytes[3] = 8'd10;
    run_cmd(2'b10, 4, -1, 0, 10, -1, 6);
    e_stb[0] = SC; e_stb[1] = mk(8,1); e_stb[2] = mk(12,1); e_stb[3] = mk(16,1);
    e_stb[4] = SC; e_stb[5] = mk(8,2); e_stb[6] = mk(12,2);
    e_stb[7] = 0; e_stb[8] = 0; e_stb[9] = 0;
    for (int w = 0; w < 10; w++) chk_eq($sformatf("macrst_stb_w%0d", w), o_stb[w], e_stb[w]);
    chk_eq("macrst_rdy_w7", o_rdy[7], 1);
    chk_eq("macrst_busy_w7", o_busy[7], 0);

`ifdef VSEQ_TIMEOUT_EN
    // LOAD_A starving after the first byte
    bytes[0] = 8'd10; bytes[1] = 8'd20; bytes[2] = 8'd30; bytes[3] = 8'd40;
    run_cmd(2'b00, 4, 1, 16, 20, -1, -1);
    for (int w = 0; w < 20; w++) begin
      chk_eq($sformatf("tmo_stb_w%0d", w), o_stb[w], (w == 1) ? mk(0,1) : 22'h0);
      chk_eq($sformatf("tmo_err_w%0d", w), o_err[w], (w == 17) ? 1 : 0);
    end
    chk_eq("tmo_rdy_w16", o_rdy[16], 0);
    chk_eq("tmo_rdy_w17", o_rdy[17], 1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
